// File: rtl/seven_seg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode seven-segment display: slot timing,
// anti-ghost guard, per-digit enables, leading-zero blanking and a tear-free update buffer.
module seven_seg_scan_ctrl #(
   parameter int CLK_DIV = 100000,
   parameter int GUARD   = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        upd_valid,
   input  logic [15:0] upd_value,
   output logic        upd_ready,
   input  logic [3:0]  digit_en,
   input  logic        lz_en,
   output logic [3:0]  bin_num,
   output logic        blank,
   output logic [3:0]  an,
   output logic        frame_tick
);

   localparam int                DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0]  GUARD_CNT = DIV_W'(GUARD);

   logic [DIV_W-1:0] r_div_cnt;
   logic [1:0]       r_idx;
   logic [15:0]      r_shown;
   logic [15:0]      r_pend_val;
   logic             r_pend;
   logic [3:0]       r_an;
   logic [3:0]       r_bin_num;
   logic             r_blank;
   logic             r_frame_tick;

   logic             w_slot_end;
   logic             w_boundary;
   logic [DIV_W-1:0] w_div_nxt;
   logic [1:0]       w_idx_nxt;
   logic [15:0]      w_shown_nxt;
   logic             w_dark;
   logic             w_accept;

   // True when the selected digit and every higher nibble are zero; digit 0 always shows.
   function automatic logic lz_dark(input logic [15:0] value, input logic [1:0] idx);
      case (idx)
         2'd1:    lz_dark = (value[15:4]  == 12'h000);
         2'd2:    lz_dark = (value[15:8]  == 8'h00);
         2'd3:    lz_dark = (value[15:12] == 4'h0);
         default: lz_dark = 1'b0;
      endcase
   endfunction

   always_comb begin
      w_slot_end  = (r_div_cnt == DIV_LAST);
      w_boundary  = w_slot_end && (r_idx == 2'd3);
      w_div_nxt   = w_slot_end ? '0 : r_div_cnt + 1'b1;
      w_idx_nxt   = w_slot_end ? r_idx + 2'd1 : r_idx;
      w_shown_nxt = (w_boundary && r_pend) ? r_pend_val : r_shown;
      w_accept    = upd_valid && !r_pend;
      w_dark      = (w_div_nxt < GUARD_CNT) || !digit_en[w_idx_nxt] ||
                    (lz_en && lz_dark(w_shown_nxt, w_idx_nxt));
   end

   // Outputs are derived from next-state values so they line up with the counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_div_cnt    <= '0;
         r_idx        <= 2'd0;
         r_shown      <= 16'h0000;
         r_pend_val   <= 16'h0000;
         r_pend       <= 1'b0;
         r_an         <= 4'b1111;
         r_bin_num    <= 4'h0;
         r_blank      <= 1'b1;
         r_frame_tick <= 1'b0;
      end else begin
         r_div_cnt <= w_div_nxt;
         r_idx     <= w_idx_nxt;
         r_shown   <= w_shown_nxt;
         if (w_boundary && r_pend) begin
            r_pend <= 1'b0;
         end else if (w_accept) begin
            r_pend     <= 1'b1;
            r_pend_val <= upd_value;
         end
         r_bin_num    <= w_shown_nxt[{w_idx_nxt, 2'b00} +: 4];
         r_an         <= w_dark ? 4'b1111 : ~(4'b0001 << w_idx_nxt);
         r_blank      <= w_dark;
         r_frame_tick <= w_boundary;
      end
   end

   assign upd_ready  = ~r_pend;
   assign an         = r_an;
   assign bin_num    = r_bin_num;
   assign blank      = r_blank;
   assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: directed scenarios then random traffic, every cycle
// compared against a position-in-frame reference model.
module tb_seven_seg_scan_ctrl;

   localparam int CLK_DIV = 8;
   localparam int GUARD   = 2;
   localparam int FRAME   = 4 * CLK_DIV;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        upd_valid;
   logic [15:0] upd_value;
   logic        upd_ready;
   logic [3:0]  digit_en;
   logic        lz_en;
   logic [3:0]  bin_num;
   logic        blank;
   logic [3:0]  an;
   logic        frame_tick;

   int checks = 0;
   int errors = 0;

   // Reference model: cycles elapsed since reset plus the two display buffers.
   int          m_p;
   logic [15:0] m_shown;
   logic [15:0] m_pval;
   logic        m_pend;
   logic        m_tick;

   always #5 clk = ~clk;

   seven_seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .GUARD(GUARD)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .upd_valid  (upd_valid),
      .upd_value  (upd_value),
      .upd_ready  (upd_ready),
      .digit_en   (digit_en),
      .lz_en      (lz_en),
      .bin_num    (bin_num),
      .blank      (blank),
      .an         (an),
      .frame_tick (frame_tick)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h pos=%0d", tag, obs, exp, m_p);
      end
   endtask

   task automatic cycle();
      logic       bnd;
      logic       dark;
      int         slot;
      int         off;
      logic [3:0] e_an;
      logic [3:0] e_bin;
      @(posedge clk);
      if (!rst_n) begin
         m_p = 0; m_shown = 16'h0; m_pval = 16'h0; m_pend = 1'b0; m_tick = 1'b0;
      end else begin
         bnd    = ((m_p % FRAME) == FRAME - 1);
         m_tick = bnd;
         if (bnd && m_pend) begin
            m_shown = m_pval;
            m_pend  = 1'b0;
         end else if (upd_valid && !m_pend) begin
            m_pval = upd_value;
            m_pend = 1'b1;
         end
         m_p++;
      end
      slot  = (m_p / CLK_DIV) % 4;
      off   = m_p % CLK_DIV;
      dark  = (off < GUARD) || !digit_en[slot] ||
              (lz_en && slot != 0 && (m_shown >> (4 * slot)) == 16'h0);
      e_bin = m_shown[4*slot +: 4];
      e_an  = dark ? 4'b1111 : ~(4'b0001 << slot);
      #1;
      chk("an",         {12'h0, an},         {12'h0, e_an});
      chk("bin_num",    {12'h0, bin_num},    {12'h0, e_bin});
      chk("blank",      {15'h0, blank},      {15'h0, dark});
      chk("frame_tick", {15'h0, frame_tick}, {15'h0, m_tick});
      chk("upd_ready",  {15'h0, upd_ready},  {15'h0, !m_pend});
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic offer(input logic [15:0] v);
      upd_valid = 1'b1;
      upd_value = v;
      cycle();
      upd_valid = 1'b0;
   endtask

   // Advance until the current cycle sits at the given position within the frame.
   task automatic to_phase(input int ph);
      for (int i = 0; i < 2 * FRAME && (m_p % FRAME) != ph; i++) cycle();
   endtask

   initial begin
      logic [15:0] rv;
      rst_n = 1'b0; upd_valid = 1'b0; upd_value = 16'h0; digit_en = 4'b1111; lz_en = 1'b0;
      m_p = 0; m_shown = 16'h0; m_pval = 16'h0; m_pend = 1'b0; m_tick = 1'b0;

      // 1: reset, then slots 0 and 1 with value zero
      run(3);
      rst_n = 1'b1;
      run(16);

      // 2: mid-frame update becomes visible at the next frame
      offer(16'h12A4);
      run(2 * FRAME);

      // 3: leading-zero suppression
      lz_en = 1'b1;
      offer(16'h0050);
      run(2 * FRAME);
      offer(16'h0000);
      run(2 * FRAME);
      lz_en = 1'b0;
      run(FRAME);

      // 4: per-digit enables
      digit_en = 4'b0101;
      offer(16'hFFFF);
      run(2 * FRAME);
      digit_en = 4'b1111;

      // 5: drop while busy, and transfer exactly on a boundary
      offer(16'h1111);
      offer(16'h2222);
      to_phase(FRAME - 1);
      cycle();
      run(4);
      to_phase(FRAME - 1);
      offer(16'h3333);
      run(2 * FRAME + 4);

      // 6: reset in slot 2 with an update pending
      offer(16'hBEEF);
      to_phase(20);
      rst_n = 1'b0;
      run(2);
      rst_n = 1'b1;
      run(40);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         rv        = 16'($urandom);
         upd_valid = ($urandom % 6) == 0;
         upd_value = rv >> ($urandom % 16);
         if (($urandom % 40) == 0) digit_en = 4'($urandom);
         if (($urandom % 60) == 0) lz_en = 1'($urandom);
         rst_n = (($urandom % 400) != 0);
         cycle();
      end
      rst_n = 1'b1;
      upd_valid = 1'b0;
      run(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
